// File: rtl/compm_mux_if.sv
// compm_mux_if: select/sample-hold/threshold bundle between the SAR/scan
// sequencer (master) and the comparator-input mux (slave).
interface compm_mux_if #(
    parameter int unsigned N = 18,
    parameter int unsigned W = 16
);
    logic [N-1:0]   dac_sel;
    logic           sh_rst;
    logic           sh_hold;
    logic [9:0]     dac_code;
    logic [N*W-1:0] v_ana_in;
    logic           comp_o;

    // Sequencer side: drives select, S/H control, threshold and channel codes.
    modport master (
        output dac_sel,
        output sh_rst,
        output sh_hold,
        output dac_code,
        output v_ana_in,
        input  comp_o
    );

    // Comparator-input mux side.
    modport slave (
        input  dac_sel,
        input  sh_rst,
        input  sh_hold,
        input  dac_code,
        input  v_ana_in,
        output comp_o
    );
endinterface

// File: rtl/compm_mux.sv
// compm_mux: comparator-input multiplexer with sample/hold and DAC threshold
// compare for the analog front-end model of the PD controller.
// Optional feature macro: COMPM_MUX_DEGLITCH_EN -- when defined, comp_o only
// changes after the raw compare has agreed on two consecutive edges.
module compm_mux #(
    parameter int unsigned N      = 18,
    parameter int unsigned W      = 16,
    parameter int unsigned LSB_MV = 2
) (
    input  logic        clk,
    input  logic        rst,
    compm_mux_if.slave  bus
);

    logic [W-1:0] w_sel_v;
    logic [W-1:0] w_dac_mv;
    logic         w_cmp_raw;
    logic [W-1:0] r_held_v;
    logic         r_comp_o;

    // Lowest-index selected channel wins; no select gives zero.
    always_comb begin
        w_sel_v = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.dac_sel[i]) begin
                w_sel_v = bus.v_ana_in[i*W +: W];
            end
        end
    end

    // DAC threshold in mV and strict unsigned compare against the held sample.
    always_comb begin
        w_dac_mv  = W'(32'(bus.dac_code) * LSB_MV);
        w_cmp_raw = (r_held_v > w_dac_mv);
    end

    // Sample/hold: clear beats hold, otherwise track when not holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held_v <= '0;
        end else if (bus.sh_rst) begin
            r_held_v <= '0;
        end else if (!bus.sh_hold) begin
            r_held_v <= w_sel_v;
        end
    end

`ifdef COMPM_MUX_DEGLITCH_EN
    logic r_raw_q;

    // Output moves only once the raw compare has repeated on two edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw_q  <= 1'b0;
            r_comp_o <= 1'b0;
        end else begin
            r_raw_q <= w_cmp_raw;
            if (w_cmp_raw == r_raw_q) begin
                r_comp_o <= w_cmp_raw;
            end
        end
    end
`else
    // Output follows the raw compare one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_comp_o <= 1'b0;
        end else begin
            r_comp_o <= w_cmp_raw;
        end
    end
`endif

    assign bus.comp_o = r_comp_o;

endmodule

// File: tb/tb_compm_mux.sv
// tb_compm_mux: scoreboard bench for compm_mux with directed scenarios and
// randomized traffic against a behavioural model.
module tb_compm_mux;

    localparam int unsigned N      = 18;
    localparam int unsigned W      = 16;
    localparam int unsigned LSB_MV = 2;
`ifdef COMPM_MUX_DEGLITCH_EN
    localparam int DG = 1;
`else
    localparam int DG = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    compm_mux_if #(.N(N), .W(W)) bus ();

    compm_mux #(.N(N), .W(W), .LSB_MV(LSB_MV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model-side copies of everything driven into the DUT.
    int unsigned    m_ch [N];
    logic [N-1:0]   m_sel;
    bit             m_shrst;
    bit             m_hold;
    int unsigned    m_code;
    // Model state.
    int unsigned    m_held;
    bit             m_comp;
    bit             m_raw_q;

    bit exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic got, logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: comp_o=%b expected %b at %0t", name, got, exp, $time);
    endfunction

    function automatic int unsigned model_sel();
        for (int i = 0; i < N; i++) if (m_sel[i]) return m_ch[i];
        return 0;
    endfunction

    task automatic model_reset();
        m_held  = 0;
        m_comp  = 1'b0;
        m_raw_q = 1'b0;
    endtask

    // Behaviour of one rising edge, from the pre-edge inputs and state.
    task automatic model_edge();
        bit raw;
        raw = (m_held > m_code * LSB_MV);
        if (DG == 0) m_comp = raw;
        else begin
            if (raw == m_raw_q) m_comp = raw;
            m_raw_q = raw;
        end
        if (m_shrst)     m_held = 0;
        else if (!m_hold) m_held = model_sel();
    endtask

    task automatic set_ch(int i, int unsigned v);
        m_ch[i] = v;
        bus.v_ana_in[i*W +: W] = W'(v);
    endtask

    task automatic drive(logic [N-1:0] sel, bit shrst, bit hold, int unsigned code);
        m_sel = sel; m_shrst = shrst; m_hold = hold; m_code = code;
        bus.dac_sel  = sel;
        bus.sh_rst   = shrst;
        bus.sh_hold  = hold;
        bus.dac_code = 10'(code);
    endtask

    // One clock: model advances at the edge and posts the expected output.
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            exp_q.push_back(m_comp);
            @(negedge clk);
        end
    endtask

    // Asynchronous reset pulse inside the low half of the clock.
    task automatic async_reset(string name);
        #1 rst = 1'b1;
        #1 check(name, bus.comp_o, 1'b0);
        model_reset();
        rst = 1'b0;
    endtask

    // Monitor: compare every registered output against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check("scoreboard", bus.comp_o, exp_q.pop_front());
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 0);
        drive('0, 1'b0, 1'b0, 0);
        model_reset();
        #1 check("reset_state", bus.comp_o, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic compare and the equality case.
        set_ch(0, 1000);
        drive(N'(1), 1'b0, 1'b0, 499);
        tick(2 + DG);
        check("basic_gt", bus.comp_o, 1'b1);
        drive(N'(1), 1'b0, 1'b0, 500);
        tick(1 + DG);
        check("basic_eq", bus.comp_o, 1'b0);

        // Hold keeps the sample while the channel moves.
        drive(N'(1), 1'b0, 1'b0, 400);
        tick(2 + DG);
        drive(N'(1), 1'b0, 1'b1, 400);
        set_ch(0, 0);
        tick(6);
        check("hold_keep", bus.comp_o, 1'b1);
        drive(N'(1), 1'b0, 1'b0, 400);
        tick(2 + DG);
        check("hold_release", bus.comp_o, 1'b0);

        // Clear beats hold.
        set_ch(0, 1000);
        drive(N'(1), 1'b0, 1'b0, 0);
        tick(2 + DG);
        check("clear_pre", bus.comp_o, 1'b1);
        drive(N'(1), 1'b1, 1'b1, 0);
        tick(2 + DG);
        check("clear", bus.comp_o, 1'b0);
        drive(N'(1), 1'b0, 1'b1, 0);
        tick(2);
        check("clear_held", bus.comp_o, 1'b0);

        // Priority and no-select.
        set_ch(3, 100);
        set_ch(7, 3000);
        drive(N'((1 << 3) | (1 << 7)), 1'b0, 1'b0, 500);
        tick(2 + DG);
        check("priority", bus.comp_o, 1'b0);
        drive('0, 1'b0, 1'b0, 500);
        tick(2 + DG);
        check("no_select", bus.comp_o, 1'b0);

        // Async reset with comp_o high, then recovery.
        set_ch(0, 2000);
        drive(N'(1), 1'b0, 1'b0, 10);
        tick(2 + DG);
        check("pre_reset", bus.comp_o, 1'b1);
        async_reset("async_reset");
        tick(2 + DG);
        check("post_reset", bus.comp_o, 1'b1);

`ifdef COMPM_MUX_DEGLITCH_EN
        // Single-cycle raw pulse is filtered; a sustained one passes.
        set_ch(0, 0);
        drive(N'(1), 1'b0, 1'b0, 0);
        tick(4);
        set_ch(0, 100);
        tick(1);
        set_ch(0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("deglitch_pulse", bus.comp_o, 1'b0);
        end
        set_ch(0, 100);
        tick(2);
        check("deglitch_first", bus.comp_o, 1'b0);
        tick(1);
        check("deglitch_second", bus.comp_o, 1'b1);
`endif

        // Randomized traffic around the threshold range.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] sel;
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0)      sel = '0;
            else if (r < 3)  sel = N'($urandom) | N'($urandom);
            else             sel = N'(1) << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) set_ch(i, $urandom_range(0, 2200));
            if ($urandom_range(0, 15) == 0) set_ch($urandom_range(0, N - 1), $urandom_range(0, 65535));
            drive(sel, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3),
                  $urandom_range(0, 1023));
            if ($urandom_range(0, 63) == 0) async_reset("rand_reset");
            tick(1);
        end

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/compm_mux.md
# compm_mux

Synthesizable comparator-input multiplexer with sample/hold and DAC threshold compare for the analog front-end model of the PD controller. It selects one of N analog channels, each presented as a millivolt code, and tracks or holds the sample. The held sample is compared against a 10-bit DAC threshold. The single-bit result feeds the core's SAR/scan logic, which sequences channel selection and DAC codes externally.

## Interface
Parameters:
- `N`, default 18: number of analog channels.
- `W`, default 16: width of each channel code (unsigned mV).
- `LSB_MV`, default 2: DAC weight in mV per code step.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `dac_sel`, input, N: channel select, one-hot intended.
- `sh_rst`, input, 1: sample/hold clear.
- `sh_hold`, input, 1: 1 = hold, 0 = track.
- `dac_code`, input, 10: comparator threshold code.
- `v_ana_in`, input, N*W: channel codes. Channel i occupies bits [i*W +: W]. Bit `dac_sel[i]` selects channel i.
- `comp_o`, output, 1: registered compare result.

## Operation
- **Selection:** `sel_v` = the channel code of the lowest index i with `dac_sel[i]=1`.
  - Lowest index wins when several select bits are set.
  - `sel_v` = 0 when no select bit is set.
- **Sample/hold register `held_v`** (W bits). Priority order per rising edge:
  1. `sh_rst=1`: `held_v <= 0`.
  2. Else `sh_hold=0`: `held_v <= sel_v` (track).
  3. Else: `held_v` unchanged (hold).
- **Threshold:** `dac_mv = dac_code * LSB_MV`.
  - Computed unsigned and zero-extended to W bits.
  - Maximum is 1023*2 = 2046 mV; no overflow at W=16.
- **Raw compare:** `cmp_raw = (held_v > dac_mv)`.
  - Strict greater-than, unsigned.
  - Equality gives 0.
- **Output:** `comp_o <= cmp_raw` on every edge (or filtered; see Configuration).
  - `comp_o` does not depend on `sh_rst` except through `held_v`.
- **No gating:** the block has no enable gating. Masking the output (for example by a DAC enable) is done outside the block.
- **Reset values:** `held_v` = 0, `comp_o` = 0, deglitch state = 0.

## Timing
- Input or select change to `held_v`: 1 edge, when tracking.
- `held_v` to `comp_o`: 1 further edge.
  - Channel change to `comp_o`: 2 cycles while tracking.
  - `dac_code` change to `comp_o`: 1 cycle.
  - With deglitch enabled, each of these is one cycle longer.
- Hold asserted at edge k: the value captured at edge k-1 is retained from edge k onward.
- Input changes during hold have no effect on `comp_o`.
- `sh_rst` and `sh_hold` asserted together: clear wins, and `held_v` = 0 at the next edge.
- `rst` mid-operation: all state clears immediately and asynchronously. Tracking resumes on the first edge after `rst` deasserts.

## Configuration
- Macro: `COMPM_MUX_DEGLITCH_EN`.
- **Defined:** `comp_o` changes only after `cmp_raw` has shown the new value on 2 consecutive edges. Single-cycle glitches are ignored.
- **Undefined:** `comp_o` follows `cmp_raw` with 1-cycle latency.

## Test plan
1. **Basic compare.** Drive `dac_sel[0]=1`, ch0=1000, `sh_hold=0`, `dac_code=499` (998 mV).
   - Required: `comp_o=1` 2 edges after select.
   - Then set `dac_code=500` (1000 mV). Required: `comp_o=0` next edge (equality case).
2. **Hold.** Track ch0=1000 with `dac_code=400`, then set `sh_hold=1` and ch0=0.
   - Required: `comp_o` stays 1 indefinitely.
   - Then set `sh_hold=0`. Required: `comp_o=0` two edges later.
3. **Clear.** Set `sh_rst=1` and `sh_hold=1` with `held_v`=1000 and `dac_code=0`.
   - Required: `held_v`=0 next edge, then `comp_o=0` (0 > 0 is false).
4. **Priority and no-select.** Set `dac_sel[3]` and `dac_sel[7]` with ch3=100, ch7=3000, `dac_code=500`.
   - Required: `comp_o=0` (ch3 wins).
   - Then set `dac_sel=0`. Required: `comp_o=0`.
5. **Async reset.** Pulse `rst` between edges while `comp_o=1`.
   - Required: `comp_o=0` immediately.
   - After release, with ch0=2000 and `dac_code=10`, required: `comp_o=1` after 2 edges.
6. **Deglitch (`COMPM_MUX_DEGLITCH_EN` defined).** Make `cmp_raw` 1 for a single cycle.
   - Required: `comp_o` stays 0.
   - With `cmp_raw` held at 1, required: `comp_o=1` on the second agreeing edge.
